fifo_flow: RTL
==============

# fifo_flow

Synchronous FIFO that buffers 12-bit transaction-layer words and provides the `empty`/`almost_full` flow-control flags the class-routing referee uses. One instance sits upstream of the referee as its source queue, where the referee reads `empty` and drives `pop`. Four instances sit downstream as per-class destination queues, where the referee reads `almost_full` and drives `push_0..3`. All state updates occur on the rising edge of `clk`.

## Interface
Parameters:
- `DATA_WIDTH`, 12, word width.
- `ADDR_WIDTH`, 3, pointer width; `DEPTH` = 2**`ADDR_WIDTH` = 8 entries.
- `AF_THRESH`, 6, `almost_full` asserts when count >= this value (1..DEPTH).
- `AE_THRESH`, 1, `almost_empty` asserts when count <= this value (0..DEPTH-1).

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on the rising edge of `clk`.
- `push`  in  1  write request.
- `data_in`  in  DATA_WIDTH  write data, sampled when a push is accepted.
- `pop`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read data.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count >= AF_THRESH.
- `almost_empty`  out  1  count <= AE_THRESH.
- `error`  out  1  sticky overflow/underflow flag; see Configuration.

## Operation
- Storage: DEPTH x DATA_WIDTH register array, plus write pointer `wr_ptr` and read pointer `rd_ptr` (ADDR_WIDTH bits each) and an occupancy counter `count`.
- Push acceptance: `push_ok = push & ~full`. When accepted, the FIFO writes `mem[wr_ptr] <= data_in` and increments `wr_ptr` modulo DEPTH (it wraps from 7 to 0).
- Pop acceptance: `pop_ok = pop & ~empty`. When accepted, `data_out <= mem[rd_ptr]` and `rd_ptr` increments modulo DEPTH.
- With no accepted pop, `data_out` holds its previous value.
- Counter update:
  - `push_ok` only: +1.
  - `pop_ok` only: -1.
  - Both or neither: unchanged.
- Simultaneous push and pop:
  - Empty: push accepted, pop ignored (no read-through); `count` goes 0 -> 1 and `data_out` is unchanged.
  - Full: pop accepted, push dropped; `count` goes DEPTH -> DEPTH-1.
  - Partially filled: both accepted; `count` unchanged.
- Flags are pure decodes of the registered `count`; no separate flag state exists.
- Reset, including a reset asserted mid-stream:
  - `wr_ptr`, `rd_ptr`, `count` and `data_out` go to 0.
  - `empty` = 1, `full` = 0, `almost_full` = 0, `almost_empty` = 1, `error` = 0.
  - Memory contents are not cleared.
  - `push` and `pop` presented in the reset cycle are ignored.

## Timing
- Write-to-flag latency: 1 cycle. A push accepted at edge N is reflected in `count`, `empty` and `almost_full` after edge N.
- Read latency: 1 cycle. `pop` sampled high at edge N makes the word valid on `data_out` after edge N.
- First-word latency: minimum 2 edges from push to data. The push is accepted at edge N, `empty` deasserts after N, and the pop at edge N+1 returns the word after N+1.
- Full throughput: one push and one pop per cycle sustained, with no bubble when 0 < count < DEPTH.
- `almost_full` is provided so an upstream producer that samples it one cycle late still has DEPTH-AF_THRESH = 2 free entries as margin.

## Configuration
- Macro: `FIFO_FLOW_ERR_EN`.
- Defined: `error` is a sticky register, set on the edge where `push & full` (overflow) or `pop & empty` (underflow) is sampled.
  - Simultaneous push and pop at full or at empty does not count as an error.
  - `error` clears only on `reset`.
- Undefined: no error logic is compiled; `error` is tied to 0. The port remains so benches bind identically.

## Test plan
- Reset then idle -> `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0, `count` = 0, `data_out` = 0x000.
- Push 0x001..0x008 on 8 consecutive cycles:
  - `almost_full` rises after the 6th push.
  - `full` rises after the 8th push.
  - A 9th push of 0xFFF is dropped; `count` stays 8, and `error` = 1 only with `FIFO_FLOW_ERR_EN`.
- From full, pop 8 times -> `data_out` returns 0x001..0x008 in order, each one cycle after its pop; `empty` = 1 after the last; a further pop leaves `data_out` = 0x008.
- Wrap-around: 20 cycles of simultaneous push (incrementing data) and pop with `count` held at 3 -> output sequence is in order with no loss across pointer wrap; `count` stays 3.
- Simultaneous push 0x0AA and pop while empty -> `count` = 1 and `data_out` unchanged; the next pop yields 0x0AA.
- Reset asserted with `count` = 5 -> on the next edge `count` = 0 and `empty` = 1; the following push/pop pair returns only the newly pushed word.

Source files
------------

// File: rtl/fifo_flow.sv
// Synchronous 8-deep FIFO with registered read data and count-decoded flow-control flags.
// Optional sticky overflow/underflow flag compiled in with FIFO_FLOW_ERR_EN.
module fifo_flow #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Handshake: push/pop are requests held for one cycle; a request takes effect only
    // when the FIFO can serve it (push needs ~full, pop needs ~empty), else it is dropped.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                data_out <= mem[rd_ptr];
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef FIFO_FLOW_ERR_EN
    logic err_q;

    // A simultaneous push+pop at a boundary is a legal exchange, not a fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((push & full & ~pop) | (pop & empty & ~push)) begin
            err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule
